odd_parity_tx: RTL and testbench

ODD_PARITY_TX -- requirements
Module: odd_parity_tx

---
 rtl/odd_parity_tx.sv | 151 +++++++++++++++
 tb/tb_odd_parity_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_parity_tx.sv
// Serial transmitter: start bit, N data bits LSB first, even-total parity bit, stop bit.
// Each bit is held for CLKS_PER_BIT cycles; ser_out, busy and frame_done are registered.
module odd_parity_tx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         ser_out,
    output logic         busy,
    output logic         frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = ($clog2(N + 1) > 1) ? $clog2(N + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // XOR of all word bits: 1 when the word holds an odd number of ones
    function automatic logic parity_f(input logic [N-1:0] word);
        return ^word;
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic           par_q, par_d;
    logic           ser_q, ser_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           bit_end_s;

    assign bit_end_s  = (cnt_q == CNT_LAST);
    assign din_ready  = (state_q == IDLE) && rst_n;
    assign ser_out    = ser_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // Next-state logic; ser_d is the line level for the cycle after the edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        ser_d   = ser_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                ser_d = 1'b1;
                if (din_valid) begin
                    state_d = START;
                    shreg_d = din;
                    par_d   = parity_f(din);
                    ser_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                    ser_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = PARITY;
                        ser_d   = par_q;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        ser_d   = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    ser_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ser_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                ser_d   = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            ser_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_odd_parity_tx.sv
// Scoreboard bench for odd_parity_tx: five instances with different N / CLKS_PER_BIT,
// accepted words are queued and a line monitor rebuilds and checks each serial frame.
module tb_odd_parity_tx;

    localparam int NI = 5;
    localparam int NS [NI] = '{8, 8, 2, 4, 6};
    localparam int CS [NI] = '{1, 4, 1, 1, 1};

    logic            clk;
    logic            rst_n;
    logic [15:0]     din_a [NI];
    logic [NI-1:0]   vld_v;
    logic [NI-1:0]   rdy_v;
    logic [NI-1:0]   ser_v;
    logic [NI-1:0]   busy_v;
    logic [NI-1:0]   done_v;

    logic [15:0]     expw [NI][64];
    int              wr [NI];
    int              rd [NI];
    logic [63:0]     cap [NI];
    int              clen [NI];
    int              idle_n [NI];
    bit              gap_chk;
    logic            rst_prev;
    int              pass_cnt;
    int              total_cnt;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NG = NS[g];
        logic rdy_s, ser_s, busy_s, done_s;
        odd_parity_tx #(.N(NG), .CLKS_PER_BIT(CS[g])) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .din        (din_a[g][NG-1:0]),
            .din_valid  (vld_v[g]),
            .din_ready  (rdy_s),
            .ser_out    (ser_s),
            .busy       (busy_s),
            .frame_done (done_s)
        );
        assign rdy_v[g]  = rdy_s;
        assign ser_v[g]  = ser_s;
        assign busy_v[g] = busy_s;
        assign done_v[g] = done_s;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference frame: sample stream the line must show, bit 0 = first cycle of start bit
    function automatic logic [63:0] exp_frame(input int n, input int c, input logic [15:0] w);
        logic [63:0] f;
        int          ones;
        int          pos;
        logic        v;
        f    = '1;
        ones = 0;
        for (int i = 0; i < n; i++) ones += w[i] ? 1 : 0;
        pos = 0;
        for (int b = 0; b < n + 3; b++) begin
            if (b == 0)           v = 1'b0;
            else if (b <= n)      v = w[b-1];
            else if (b == n + 1)  v = (ones % 2 == 1);
            else                  v = 1'b1;
            for (int r = 0; r < c; r++) begin
                f[pos] = v;
                pos++;
            end
        end
        return f;
    endfunction

    task automatic frame_check(input int k);
        int          n, c, len;
        logic [15:0] w;
        logic [63:0] mask;
        logic        par;
        n = NS[k];
        c = CS[k];
        chk("sb_nonempty", k, 64'(wr[k] != rd[k]), 64'd1);
        if (wr[k] != rd[k]) begin
            w = expw[k][rd[k] % 64];
            rd[k]++;
            len  = (n + 3) * c;
            mask = (64'h1 << len) - 64'h1;
            chk("frame_len", k, 64'(clen[k]), 64'(len));
            chk("frame_bits", k, cap[k] & mask, exp_frame(n, c, w) & mask);
            par = 1'b0;
            for (int b = 1; b <= n + 1; b++) par ^= cap[k][b*c];
            chk("parity_xor", k, 64'(par), 64'd0);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk("din_ready", k, 64'(rdy_v[k]), 64'(rst_n & ~busy_v[k]));
                if (!rst_n) begin
                    if (!rst_prev) begin
                        chk("rst_ser", k, 64'(ser_v[k]), 64'd1);
                        chk("rst_busy", k, 64'(busy_v[k]), 64'd0);
                        chk("rst_done", k, 64'(done_v[k]), 64'd0);
                    end
                    clen[k]   = 0;
                    rd[k]     = wr[k];
                    idle_n[k] = 0;
                end else if (!busy_v[k]) begin
                    chk("idle_line", k, 64'(ser_v[k]), 64'd1);
                    chk("idle_done", k, 64'(done_v[k]), 64'd0);
                    if (clen[k] != 0) begin
                        chk("missing_done", k, 64'(clen[k]), 64'd0);
                        clen[k] = 0;
                    end
                    idle_n[k]++;
                end else begin
                    if (gap_chk && k == 0 && clen[k] == 0)
                        chk("b2b_gap", k, 64'(idle_n[k]), 64'd1);
                    idle_n[k] = 0;
                    if (clen[k] < 64) cap[k][clen[k]] = ser_v[k];
                    clen[k]++;
                    if (done_v[k]) begin
                        frame_check(k);
                        clen[k] = 0;
                    end
                end
            end
            rst_prev = rst_n;
        end
    endtask

    // sel 0 waits for din_ready, sel 1 for frame_done; returns 1 when seen in time
    task automatic wait_sig(input int k, input int sel, output bit ok);
        int t;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 2000) begin
            @(negedge clk);
            ok = (sel == 0) ? rdy_v[k] : done_v[k];
            t++;
        end
        if (!ok) chk(sel == 0 ? "accept_timeout" : "done_timeout", k, 64'd0, 64'd1);
    endtask

    task automatic push(input int k, input logic [15:0] w);
        expw[k][wr[k] % 64] = w;
        wr[k]++;
    endtask

    task automatic send(input int k, input logic [15:0] w);
        bit ok;
        din_a[k] = w;
        vld_v[k] = 1'b1;
        wait_sig(k, 0, ok);
        if (ok) begin
            @(posedge clk);
            push(k, w);
            #1;
        end
        vld_v[k] = 1'b0;
        din_a[k] = 16'($urandom);
    endtask

    task automatic gap(input int maxc);
        repeat ($urandom_range(0, maxc)) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic stimulus();
        bit ok;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        gap(2);

        send(0, 16'h00A5);
        gap(2);

        // back-to-back words with din changed while the first frame is in flight
        din_a[0] = 16'h0001;
        vld_v[0] = 1'b1;
        wait_sig(0, 0, ok);
        @(posedge clk);
        push(0, 16'h0001);
        #1 din_a[0] = 16'h0002;
        wait_sig(0, 1, ok);
        @(posedge clk);
        #1 gap_chk = 1'b1;
        wait_sig(0, 0, ok);
        @(posedge clk);
        push(0, 16'h0002);
        #1 vld_v[0] = 1'b0;
        din_a[0] = 16'h00FF;
        @(negedge clk);
        #1 gap_chk = 1'b0;
        wait_sig(0, 1, ok);
        gap(2);

        // reset during data bit 3, then no further frame bits
        send(0, 16'h00C3);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            send(0, 16'($urandom_range(0, 255)));
            gap(3);
        end

        send(1, 16'h0007);
        for (int i = 0; i < 8; i++) begin
            gap(3);
            send(1, 16'($urandom_range(0, 255)));
        end

        for (int k = 2; k < NI; k++) begin
            for (int w = 0; w < (1 << NS[k]); w++) begin
                send(k, 16'(w));
                if ($urandom_range(0, 3) == 0) gap(2);
            end
        end

        repeat (80) @(posedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) chk("drained", k, 64'(wr[k] - rd[k]), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        vld_v     = '0;
        gap_chk   = 1'b0;
        rst_prev  = 1'b0;
        pass_cnt  = 0;
        total_cnt = 0;
        for (int k = 0; k < NI; k++) begin
            din_a[k]  = 16'h0000;
            wr[k]     = 0;
            rd[k]     = 0;
            clen[k]   = 0;
            idle_n[k] = 0;
            cap[k]    = '0;
        end
        fork
            monitor();
            stimulus();
        join_any
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
